// File: rtl/bldc_commutator.sv
// Hall-sensor BLDC commutator with glitch filtering, dead-time insertion and
// shoot-through-safe six-step gate drive; also measures the hall period.
`timescale 1ns/1ps
module bldc_commutator #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned DEAD_TIME  = 16,
    parameter int unsigned PERIOD_W   = 20,
    parameter logic [2:0]  HALL_INV   = 3'b000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                forward,
    input  logic                halla,
    input  logic                hallb,
    input  logic                hallc,
    output logic                ha,
    output logic                hb,
    output logic                hc,
    output logic                la,
    output logic                lb,
    output logic                lc,
    output logic [2:0]          sector,
    output logic                fault,
    output logic [PERIOD_W-1:0] hall_period,
    output logic                period_valid
);

    typedef enum logic [1:0] {IDLE, DEAD, DRIVE, FAULT} state_t;

    localparam logic [7:0]          FILT_N   = FILTER_LEN[7:0];
    localparam logic [15:0]         DEAD_N   = DEAD_TIME[15:0];
    localparam logic [2:0]          NO_SECT  = 3'd7;
    localparam logic [PERIOD_W-1:0] PER_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_t              state, state_next;
    logic [2:0]          sync1, sync2, hall_code, cand, code_sect;
    logic [1:0]          warm;
    logic [7:0]          cnt, cnt_next;
    logic                same, accept, code_bad, fault_set, valid_change;
    logic [15:0]         dcnt;
    logic [5:0]          target, drive_pat, gates;
    logic [PERIOD_W-1:0] pcnt;

    function automatic logic [2:0] decode(input logic [2:0] c);
        logic [2:0] s;
        case (c)
            3'b101:  s = 3'd0;
            3'b100:  s = 3'd1;
            3'b110:  s = 3'd2;
            3'b010:  s = 3'd3;
            3'b011:  s = 3'd4;
            3'b001:  s = 3'd5;
            default: s = 3'd7;
        endcase
        return s;
    endfunction

    // Pattern bits are {ha,hb,hc,la,lb,lc}; each entry pairs distinct phases.
    function automatic logic [5:0] pattern(input logic [2:0] s, input logic fwd);
        logic [5:0] p;
        case (s)
            3'd0:    p = fwd ? 6'b010_100 : 6'b100_010;
            3'd1:    p = fwd ? 6'b001_100 : 6'b100_001;
            3'd2:    p = fwd ? 6'b001_010 : 6'b010_001;
            3'd3:    p = fwd ? 6'b100_010 : 6'b010_100;
            3'd4:    p = fwd ? 6'b100_001 : 6'b001_100;
            3'd5:    p = fwd ? 6'b010_001 : 6'b001_010;
            default: p = '0;
        endcase
        return p;
    endfunction

    // Warm-up flag keeps the filter idle until the sync pipeline holds real samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            warm  <= '0;
        end else begin
            sync1 <= {halla, hallb, hallc};
            sync2 <= sync1;
            warm  <= {warm[0], 1'b1};
        end
    end

    assign hall_code = sync2 ^ HALL_INV;

    always_comb begin
        same = (hall_code == cand);
        if (!same)
            cnt_next = 8'd1;
        else if (cnt == FILT_N)
            cnt_next = cnt;
        else
            cnt_next = cnt + 8'd1;
        accept       = warm[1] && (cnt_next == FILT_N) && !(same && (cnt == FILT_N));
        code_sect    = decode(hall_code);
        code_bad     = (code_sect == NO_SECT);
        fault_set    = accept && code_bad;
        valid_change = accept && !code_bad && (code_sect != sector);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cand <= '0;
            cnt  <= '0;
        end else if (warm[1]) begin
            cand <= hall_code;
            cnt  <= cnt_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sector       <= NO_SECT;
            fault        <= 1'b0;
            pcnt         <= '0;
            hall_period  <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (pcnt != '1)
                pcnt <= pcnt + PER_ONE;
            if (fault_set)
                fault <= 1'b1;
            else if (!enable)
                fault <= 1'b0;
            // The first acceptance after reset only restarts the period count.
            if (valid_change) begin
                sector <= code_sect;
                pcnt   <= PER_ONE;
                if (sector != NO_SECT) begin
                    hall_period  <= pcnt;
                    period_valid <= 1'b1;
                end
            end
        end
    end

    assign target = pattern(sector, forward);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (enable && !fault && (sector != NO_SECT)) state_next = DEAD;
            DEAD:    if (dcnt == DEAD_N) state_next = DRIVE;
            DRIVE:   if (target != drive_pat) state_next = DEAD;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
        if (!enable)
            state_next = IDLE;
        if (fault_set)
            state_next = FAULT;
    end

    // dcnt sits at 1 outside DEAD so the first DEAD cycle is already counted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dcnt      <= '0;
            drive_pat <= '0;
        end else begin
            state <= state_next;
            if (state != DEAD)
                dcnt <= 16'd1;
            else
                dcnt <= dcnt + 16'd1;
            if ((state == DEAD) && (state_next == DRIVE))
                drive_pat <= target;
        end
    end

    always_comb begin
        gates = '0;
        if (state == DRIVE)
            gates = drive_pat;
        {ha, hb, hc, la, lb, lc} = gates;
    end

endmodule

// File: doc/bldc_commutator.md
BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive stable samples (1..255) required to accept a hall code.
REQ-002 SHALL have parameter DEAD_TIME, default 16: all-switches-off cycles (1..65535) inserted before each new drive pattern.
REQ-003 SHALL have parameter PERIOD_W, default 20: width of the hall-period counter.
REQ-004 SHALL have parameter HALL_INV, default 3'b000: per-line polarity mask {a,b,c} XORed onto the synchronised hall inputs.
REQ-005 SHALL have port clock  in  1  the single clock; all flops are on the rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous reset, active low.
REQ-007 SHALL have port enable  in  1  drive permit; 0 forces all switches off.
REQ-008 SHALL have port forward  in  1  direction: 1 forward, 0 reverse.
REQ-009 SHALL have ports halla, hallb, hallc  in  1 each  raw asynchronous hall sensor lines.
REQ-010 SHALL have ports ha, hb, hc  out  1 each  high-side gate commands.
REQ-011 SHALL have ports la, lb, lc  out  1 each  low-side gate commands.
REQ-012 SHALL have port sector  out  3  accepted sector 0..5; 7 = none accepted yet.
REQ-013 SHALL have port fault  out  1  sticky invalid-hall fault.
REQ-014 SHALL have port hall_period  out  PERIOD_W  cycles between the last two accepted sector changes.
REQ-015 SHALL have port period_valid  out  1  one-cycle strobe when hall_period updates.

Function
REQ-016 SHALL synchronise each hall line through 2 flops, then XOR the result with HALL_INV.
REQ-017 SHALL accept a code only after the synchronised code has been identical for FILTER_LEN consecutive cycles; any change restarts the count.
REQ-018 SHALL decode accepted codes {a,b,c} as: 101->0, 100->1, 110->2, 010->3, 011->4, 001->5.
REQ-019 SHALL treat an accepted code of 000 or 111 as invalid: set fault, leave sector unchanged.
REQ-020 SHALL drive the forward pattern by sector as: 0 hb+la, 1 hc+la, 2 hc+lb, 3 ha+lb, 4 ha+lc, 5 hb+lc.
REQ-021 SHALL drive the reverse pattern by sector as: 0 ha+lb, 1 ha+lc, 2 hb+lc, 3 hb+la, 4 hc+la, 5 hc+lb.
REQ-022 SHALL implement an FSM with states IDLE, DEAD, DRIVE and FAULT.
REQ-023 SHALL hold all six gates at 0 in every state except DRIVE.
REQ-024 SHALL move IDLE->DEAD when enable=1, fault=0 and sector!=7.
REQ-025 SHALL move DEAD->DRIVE after exactly DEAD_TIME cycles in DEAD, applying the target pattern current at that edge.
REQ-026 SHALL move DRIVE->DEAD in the cycle after the target pattern changes (sector change or forward toggle).
REQ-027 SHALL not restart the dead count when the target changes while in DEAD; the latest target is applied at expiry.
REQ-028 SHALL move any state->IDLE when enable=0; this transition takes priority over every other except FAULT entry.
REQ-029 SHALL move any state->FAULT when fault sets, in the same cycle.
REQ-030 SHALL keep fault set until enable=0, which clears fault and enters IDLE.
REQ-031 SHALL never assert ha&la, hb&lb or hc&lc simultaneously, under any input sequence.
REQ-032 SHALL run a period counter that increments every cycle and saturates at 2^PERIOD_W-1.
REQ-033 SHALL, on each accepted valid sector change, load hall_period with the counter value, reset the counter to 1 and pulse period_valid.
REQ-034 SHALL not update hall_period on the first acceptance after reset (sector 7 -> valid); this acceptance only resets the counter.
REQ-035 SHALL report a saturated value in hall_period as all ones (stall indication).

Reset
REQ-036 SHALL, on reset low, asynchronously force: gates 0, sector 7, fault 0, hall_period 0, period_valid 0, FSM to IDLE, filter and counters to 0.
REQ-037 SHALL, when reset is asserted mid-DRIVE, drop all gates to 0 immediately, without waiting for a clock edge.

Verification
REQ-038 SHALL pass: defaults, enable=1, forward=1, hall 101 held -> sector=0 after 2+4 cycles; hb+la high 16 cycles later.
REQ-039 SHALL pass: in DRIVE at sector 0, hall changes to 100 -> all gates 0 for exactly 16 cycles, then hc+la.
REQ-040 SHALL pass: in DRIVE at sector 3, toggle forward 1->0 -> 16 dead cycles, then hb+la.
REQ-041 SHALL pass: 3-cycle glitch 101->100->101 -> sector stays 0, no dead-time, no period_valid.
REQ-042 SHALL pass: hall 111 held 4 cycles -> fault=1, gates 0; enable pulsed low -> fault=0, IDLE.
REQ-043 SHALL pass: sectors advancing every 1000 cycles -> hall_period=1000 with one period_valid pulse per change; reset low mid-DRIVE -> gates 0 asynchronously.
